// File: rtl/lut_neuron_prog.sv
// Runtime-programmable LUT neuron: a config stream loads the truth table, then a
// valid/ready lookup path evaluates it with a registered output.
module lut_neuron_prog #(
    parameter int unsigned IN_BITS  = 6,
    parameter int unsigned OUT_BITS = 1,
    parameter int unsigned CFG_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CFG_W-1:0]    cfg_data,
    input  logic                cfg_last,
    output logic                cfg_err,
    output logic                table_valid,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  M0,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] M1
);

    localparam int unsigned DEPTH = 1 << IN_BITS;
    localparam int unsigned TBITS = DEPTH * OUT_BITS;
    localparam int unsigned BEATS = TBITS / CFG_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {StEmpty, StLoad, StArmed} state_e;

    state_e              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_err, w_err_nxt;
    logic [TBITS-1:0]    r_table;
    logic                r_out_valid;
    logic [OUT_BITS-1:0] r_m1;
    logic                w_cfg_acc;
    logic                w_in_acc;
    logic [CNT_W-1:0]    w_wr_idx;

    assign w_cfg_acc = cfg_valid && cfg_ready;
    assign w_in_acc  = in_valid && in_ready;
    // Any beat accepted outside LOAD (first load or reload) is beat 0.
    assign w_wr_idx  = (r_state == StLoad) ? r_cnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StEmpty;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        if (w_cfg_acc) begin
            if ((w_wr_idx == LAST_IDX) && cfg_last) begin
                w_state_nxt = StArmed;
                w_cnt_nxt   = '0;
            end else if ((w_wr_idx == LAST_IDX) || cfg_last) begin
                w_state_nxt = StEmpty;
                w_cnt_nxt   = '0;
                w_err_nxt   = 1'b1;
            end else begin
                w_state_nxt = StLoad;
                w_cnt_nxt   = w_wr_idx + 1'b1;
            end
        end
    end

    always_comb begin
        cfg_ready   = 1'b1;
        in_ready    = 1'b0;
        table_valid = 1'b0;
        unique case (r_state)
            StEmpty, StLoad: begin
                cfg_ready = 1'b1;
            end
            StArmed: begin
                // Config has priority; a held result blocks a reload until it drains.
                cfg_ready   = !r_out_valid;
                in_ready    = !cfg_valid && (!r_out_valid || out_ready);
                table_valid = 1'b1;
            end
            default: begin
                cfg_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_cfg_acc) begin
            r_table[w_wr_idx*CFG_W +: CFG_W] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_m1        <= '0;
        end else if (w_in_acc) begin
            r_out_valid <= 1'b1;
            r_m1        <= r_table[M0*OUT_BITS +: OUT_BITS];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign cfg_err   = r_err;
    assign out_valid = r_out_valid;
    assign M1        = r_m1;

endmodule

// File: doc/lut_neuron_prog.md
Name: lut_neuron_prog

Overview:
- Runtime-programmable LogicNets neuron: the writer side of a fixed truth-table neuron.
- A config stream loads the 2^IN_BITS-entry truth table into registers.
- A valid/ready lookup path then evaluates the neuron with registered output.
- Used to swap trained neuron tables in-system without resynthesis; same input/output encoding as the generated layer neurons.

Parameters:
- IN_BITS, 6, neuron fan-in bits; table depth DEPTH = 2^IN_BITS.
- OUT_BITS, 1, output bits per entry.
- CFG_W, 8, config beat width. DEPTH*OUT_BITS must be a multiple of CFG_W. BEATS = DEPTH*OUT_BITS/CFG_W (8 at defaults).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_valid  in  1  config beat valid.
- cfg_ready  out  1  config beat accepted when cfg_valid&&cfg_ready.
- cfg_data  in  CFG_W  table bits; beat k carries table bits [k*CFG_W +: CFG_W].
- cfg_last  in  1  marks final beat.
- cfg_err  out  1  one-cycle pulse on malformed load.
- table_valid  out  1  table fully loaded and usable.
- in_valid  in  1  lookup request valid.
- in_ready  out  1  lookup accepted when in_valid&&in_ready.
- M0  in  IN_BITS  lookup address (neuron input).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- M1  out  OUT_BITS  neuron output = table bits [M0*OUT_BITS +: OUT_BITS].

Behaviour:
- Entry mapping:
  - entry i occupies table bits [i*OUT_BITS +: OUT_BITS]; LSB first.
  - beat 0 bit 0 = entry 0.
- Reset values:
  - state EMPTY, beat counter 0, table_valid 0, out_valid 0, M1 0, cfg_err 0.
  - Table contents are don't-care; clearing them is not required.
- FSM states: EMPTY, LOAD, ARMED.
  - EMPTY: cfg_ready=1, in_ready=0. An accepted beat writes beat 0, sets cnt=1, goes to LOAD. If BEATS==1 the beat is handled as the final beat.
  - LOAD: cfg_ready=1, in_ready=0. Each accepted beat writes slice cnt and increments cnt.
    - Normal completion: beat with cnt==BEATS-1 and cfg_last=1 -> ARMED, table_valid=1 from the next cycle.
    - cfg_last=1 with cnt<BEATS-1, or cfg_last=0 on cnt==BEATS-1 -> cfg_err pulse, cnt=0, EMPTY. Table stays invalid.
  - ARMED: table_valid=1.
    - in_ready = !cfg_valid && (!out_valid || out_ready).
    - cfg_ready = !out_valid.
    - An accepted cfg beat (reload) drops table_valid next cycle, writes beat 0, and enters LOAD; the old table is invalid from that point.
- Lookup path:
  - Accepted request -> M1 registered, out_valid=1 next cycle (latency 1).
  - The table read uses the table contents at acceptance.
  - out_valid&&!out_ready: M1 and out_valid hold stable, in_ready=0.
  - Full throughput: 1 result/cycle when out_ready=1.
  - out_valid clears on handshake with no new accept.
- Simultaneous cfg_valid and in_valid in ARMED: config has priority; lookups stall (in_ready=0) while cfg_valid=1.
- Outstanding result: a result already in the output register completes normally even if a reload begins.
- cfg_valid in ARMED with out_valid=1: cfg_ready=0 until the result drains.
- Reset mid-load or mid-lookup: everything returns to reset values next cycle; the partial load is discarded and the next beat is beat 0.
- cfg_err is a single-cycle pulse; it never asserts on the normal completion path.

Test Plan:
- Load 8 beats {0x00,0x00,0x10,0x00,0x00,0x00,0x00,0x80}, last on beat 7 -> table_valid=1 next cycle.
  - Then M0=6'h14 -> M1=1, and M0=6'h13 -> M1=0, each one cycle after accept.
  - Then M0=6'h3F -> M1=1.
- Early last: cfg_last=1 on beat 4 -> cfg_err=1 for exactly one cycle, table_valid=0, in_ready=0.
  - A following full 8-beat load succeeds.
- Backpressure: table armed, out_ready=0 with 3 lookups offered -> one result held with M1 stable, in_ready=0.
  - Release out_ready -> remaining 2 results on consecutive cycles, in order.
- Reset mid-load: rst asserted after beat 3 -> table_valid=0, cfg_err=0.
  - Fresh 8-beat all-0xFF load -> every M0 yields M1=1.
- Reload while armed: lookups streaming, cfg_valid raised -> in_ready=0, in-flight result delivered, table_valid drops.
  - Load 8 beats of 0x00 -> M0=6'h14 now yields M1=0.
- Missing last: 8 beats with cfg_last=0 -> cfg_err pulse on beat 7, state EMPTY, table_valid=0.
